ic_fill_ctrl: RTL and testbench
===============================

Name: ic_fill_ctrl

Overview:
- Responder for the icache miss interface: accepts ic_miss/ic_miss_addr, fetches the 32-byte line from memory as a burst of 64-bit beats, assembles the 256-bit line, and returns it on ic_fill_data with a one-cycle ic_miss_ack.
- Sits between the fetch-stage icache and the memory bus arbiter.
- Handles one miss at a time and drops fills cancelled by ic_exp.

Parameters:
- BEAT_W, 64, memory read-data width in bits.
- NBEATS, 4, beats per line; BEAT_W*NBEATS must equal 256.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ic_miss  input  1  icache miss request, level; held until serviced or cancelled.
- ic_miss_addr  input  32  miss address; bits [4:0] ignored.
- ic_exp  input  1  fetch exception/flush; cancels the outstanding miss.
- mem_req  output  1  burst read request to arbiter.
- mem_addr  output  32  line-aligned burst address.
- mem_gnt  input  1  arbiter grant for mem_req.
- mem_rdata  input  BEAT_W  read beat.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- ic_fill_data  output  256  assembled line to icache.
- ic_miss_ack  output  1  one-cycle fill strobe; icache writes tag/data during it.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; mem_req=0, mem_addr=0, ic_fill_data=0, ic_miss_ack=0, busy=0, beat_cnt=0, abort=0. Reset overrides any state, including mid-burst; in-flight beats after reset are ignored because the block is in IDLE.
- States: IDLE, REQ, FILL, ACK, DRAIN.
- IDLE:
  - If ic_miss=1 and ic_exp=0: latch line_addr={ic_miss_addr[31:5],5'b0} and go to REQ.
  - Otherwise stay. ic_miss with ic_exp=1 is ignored.
- REQ:
  - mem_req=1, mem_addr=line_addr.
  - If ic_exp=1 and mem_gnt=0: mem_req drops next cycle and go to IDLE (no burst issued).
  - If mem_gnt=1: go to FILL with beat_cnt=0. If ic_exp=1 in the same cycle, also set abort=1.
  - mem_req stays asserted until the grant.
- FILL:
  - mem_req=0.
  - Each cycle with mem_rvalid=1: write mem_rdata into ic_fill_data[beat_cnt*BEAT_W +: BEAT_W] (beat 0 fills bits [63:0]) and increment beat_cnt.
  - Cycles without mem_rvalid hold all state. There is no timeout.
  - ic_exp=1 in any FILL cycle sets abort=1. The burst is still consumed to keep the bus protocol intact.
  - When the beat with beat_cnt=NBEATS-1 is accepted: go to ACK if abort=0 (counting ic_exp in that same cycle), otherwise go to DRAIN.
- ACK:
  - ic_miss_ack=1 for exactly one cycle, then go to IDLE.
  - ic_fill_data is stable during ACK and holds its value until the next fill writes beats.
  - If ic_exp=1 during ACK, the ack is still issued; the icache masks the hit.
- DRAIN:
  - One cycle, no ack. Clear abort and beat_cnt, then go to IDLE.
  - ic_fill_data keeps the partial/aborted contents; it is not consumed.
- mem_rvalid outside FILL is ignored.
- mem_gnt and mem_rvalid never arrive in the same cycle; the first beat comes at least one cycle after the grant.
- Back-to-back misses: the icache writes during the ACK cycle, so ic_miss for the same line is low in the IDLE cycle after ACK. A new miss seen in that IDLE cycle enters REQ on the next edge.
- Minimum miss latency, from ic_miss sampled in IDLE to ic_miss_ack, with gnt in the first REQ cycle and back-to-back rvalids: 1 (REQ) + 1 (gnt-to-first-beat gap) + 4 (FILL) + ack = ic_miss_ack high in cycle 7.
- beat_cnt is $clog2(NBEATS) bits and wraps to 0 on the last beat.
- busy = (state != IDLE).

Test Plan:
- Reset, then ic_miss=1, ic_miss_addr=0x0000_1A37, gnt after 2 REQ cycles, beats 0x1111..., 0x2222..., 0x3333..., 0x4444... with no gaps -> mem_addr=0x0000_1A20; one-cycle ic_miss_ack; ic_fill_data={0x4444...,0x3333...,0x2222...,0x1111...}; mem_req is high for exactly 2 cycles.
- Same miss, but mem_rvalid gaps of 0, 3, 1 idle cycles between beats -> identical ic_fill_data; ack comes 4 cycles later than in the first scenario.
- ic_exp pulse in REQ before grant -> mem_req drops next cycle, state returns to IDLE, no ack; a following miss to 0x40 issues mem_addr=0x0000_0040.
- ic_exp pulse after beat 1 -> beats 2-3 are consumed, no ic_miss_ack, busy drops 1 cycle after the last beat; stray mem_rvalid in IDLE leaves ic_fill_data unchanged.
- rst asserted after beat 2 -> next cycle all outputs are 0 and state is IDLE; a new miss completes normally with fresh data and no leftover beats.
- ic_miss held through ACK, then a new miss at 0x0000_0100 in the next IDLE cycle -> second mem_req asserts 2 cycles after the first ack; two acks in total.

Source files
------------

// File: rtl/ic_fill_ctrl_if.sv
// Miss/fill bundle between icache, fill controller and memory arbiter.
// The controller takes the slave view; the icache/memory side the master view.
interface ic_fill_ctrl_if #(
  parameter int BEAT_W = 64
);
  logic              ic_miss;
  logic [31:0]       ic_miss_addr;
  logic              ic_exp;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_gnt;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [255:0]      ic_fill_data;
  logic              ic_miss_ack;
  logic              busy;

  modport slave (
    input  ic_miss, ic_miss_addr, ic_exp,
    input  mem_gnt, mem_rdata, mem_rvalid,
    output mem_req, mem_addr,
    output ic_fill_data, ic_miss_ack, busy
  );

  modport master (
    output ic_miss, ic_miss_addr, ic_exp,
    output mem_gnt, mem_rdata, mem_rvalid,
    input  mem_req, mem_addr,
    input  ic_fill_data, ic_miss_ack, busy
  );
endinterface

// File: rtl/ic_fill_ctrl.sv
// Icache line fill controller: one miss at a time, burst read of
// NBEATS beats, assembles the line and strobes ic_miss_ack once.
module ic_fill_ctrl #(
  parameter int BEAT_W = 64,
  parameter int NBEATS = 4
) (
  input logic           clk,
  input logic           rst,
  ic_fill_ctrl_if.slave bus
);

  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    ACK,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          abort;

  // Miss FSM; all outputs are registered and mem_addr holds the line address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      abort            <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_addr     <= '0;
      bus.ic_fill_data <= '0;
      bus.ic_miss_ack  <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ic_miss && !bus.ic_exp) begin
            bus.mem_addr <= {bus.ic_miss_addr[31:5], 5'b0};
            bus.mem_req  <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            beat_cnt    <= '0;
            abort       <= bus.ic_exp;
            state       <= FILL;
          end else if (bus.ic_exp) begin
            bus.mem_req <= 1'b0;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        FILL: begin
          if (bus.ic_exp) begin
            abort <= 1'b1;
          end
          if (bus.mem_rvalid) begin
            for (int b = 0; b < NBEATS; b++) begin
              if (beat_cnt == CW'(b)) begin
                bus.ic_fill_data[b*BEAT_W +: BEAT_W] <= bus.mem_rdata;
              end
            end
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST) begin
              if (abort || bus.ic_exp) begin
                state <= DRAIN;
              end else begin
                bus.ic_miss_ack <= 1'b1;
                state           <= ACK;
              end
            end
          end
        end
        ACK: begin
          bus.ic_miss_ack <= 1'b0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        DRAIN: begin
          abort    <= 1'b0;
          beat_cnt <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Bench for ic_fill_ctrl: table of fills plus hand-written
// cancel, reset and back-to-back sequences; scoreboard on acks.
module tb_ic_fill_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ic_fill_ctrl_if #(.BEAT_W(64)) bus ();

  ic_fill_ctrl #(
    .BEAT_W(64),
    .NBEATS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0]  addr;
    int           gnt_dly;
    int           gap0;
    int           gap1;
    int           gap2;
    int           exp_after;
    logic [255:0] line;
    logic [31:0]  maddr;
    int           lat;
    bit           ack;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          ack_cnt = 0;
  bit          prev_ack = 1'b0;
  logic [255:0] exp_q[$];
  vec_t        tbl[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the expected line.
  always @(negedge clk) begin
    if (bus.ic_miss_ack === 1'b1) begin
      ack_cnt++;
      chk("ack_one_cycle", prev_ack, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack expected none");
      end else begin
        chk("fill_data", bus.ic_fill_data, exp_q.pop_front());
      end
    end
    prev_ack = bus.ic_miss_ack;
  end

  task automatic run_fill(input vec_t v,
                          input bit skip_start,
                          input bit hold,
                          input logic [31:0] next_addr);
    int unsigned t0;
    int gp[3];
    gp[0] = v.gap0;
    gp[1] = v.gap1;
    gp[2] = v.gap2;
    if (!skip_start) begin
      @(negedge clk);
      bus.ic_miss      = 1'b1;
      bus.ic_miss_addr = v.addr;
    end
    t0 = cyc;
    if (v.ack) exp_q.push_back(v.line);
    @(negedge clk);
    chk("req_addr", bus.mem_addr, v.maddr);
    for (int k = 1; k <= v.gnt_dly; k++) begin
      chk("req_high", bus.mem_req, 1);
      if (k == v.gnt_dly) bus.mem_gnt = 1'b1;
      @(negedge clk);
    end
    bus.mem_gnt = 1'b0;
    chk("req_low_after_gnt", bus.mem_req, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = v.line[i*64 +: 64];
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (i < 3) begin
        repeat (gp[i]) @(negedge clk);
        if (i == v.exp_after) begin
          bus.ic_exp  = 1'b1;
          bus.ic_miss = 1'b0;
          @(negedge clk);
          bus.ic_exp = 1'b0;
        end
      end
    end
    if (v.ack) begin
      chk("ack_high", bus.ic_miss_ack, 1);
      chk("ack_latency", cyc - t0, v.lat);
      if (hold) bus.ic_miss_addr = next_addr;
      else bus.ic_miss = 1'b0;
      @(negedge clk);
      chk("ack_low", bus.ic_miss_ack, 0);
      chk("idle_busy", bus.busy, 0);
    end else begin
      chk("drain_no_ack", bus.ic_miss_ack, 0);
      chk("drain_busy", bus.busy, 1);
      @(negedge clk);
      chk("drain_busy_low", bus.busy, 0);
      chk("drain_idle_no_ack", bus.ic_miss_ack, 0);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req"}, bus.mem_req, 0);
    chk({nm, "_addr"}, bus.mem_addr, 0);
    chk({nm, "_data"}, bus.ic_fill_data, 0);
    chk({nm, "_ack"}, bus.ic_miss_ack, 0);
    chk({nm, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va;
    vec_t vb;
    vec_t vc;
    vec_t vd;
    int   acks0;

    tbl[0] = '{32'h0000_1A37, 2, 0, 0, 0, -1,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               32'h0000_1A20, 8, 1'b1};
    tbl[1] = '{32'h0000_1A37, 2, 0, 3, 1, -1,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               32'h0000_1A20, 12, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 1, 1, 0, 2, -1,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0},
               32'hFFFF_FFE0, 10, 1'b1};
    tbl[3] = '{32'h2000_0044, 1, 0, 0, 0, 1,
               {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
               32'h2000_0040, 0, 1'b0};

    bus.ic_miss      = 1'b0;
    bus.ic_miss_addr = '0;
    bus.ic_exp       = 1'b0;
    bus.mem_gnt      = 1'b0;
    bus.mem_rdata    = '0;
    bus.mem_rvalid   = 1'b0;
    rst              = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_fill(tbl[i], 1'b0, 1'b0, 32'h0);
    end

    chk("abort_data_kept", bus.ic_fill_data, tbl[3].line);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid", bus.ic_fill_data, tbl[3].line);
    chk("stray_busy", bus.busy, 0);

    // Cancel in REQ before the grant.
    @(negedge clk);
    bus.ic_miss      = 1'b1;
    bus.ic_miss_addr = 32'h0000_0080;
    @(negedge clk);
    chk("cancel_req_high", bus.mem_req, 1);
    bus.ic_exp  = 1'b1;
    bus.ic_miss = 1'b0;
    @(negedge clk);
    bus.ic_exp = 1'b0;
    chk("cancel_req_low", bus.mem_req, 0);
    chk("cancel_busy", bus.busy, 0);
    @(negedge clk);
    chk("cancel_stays_idle", bus.mem_req, 0);
    va = '{32'h0000_0040, 1, 0, 0, 0, -1,
           {64'hAAAA_0000_0000_0004, 64'hAAAA_0000_0000_0003,
            64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001},
           32'h0000_0040, 7, 1'b1};
    run_fill(va, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a burst.
    @(negedge clk);
    bus.ic_miss      = 1'b1;
    bus.ic_miss_addr = 32'h0000_3000;
    @(negedge clk);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'hBAD0_0000_0000_0000 | 64'(i);
      @(negedge clk);
    end
    rst            = 1'b1;
    bus.ic_miss    = 1'b0;
    bus.mem_rdata  = 64'hBAD0_0000_0000_0003;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("midrst_stray", bus.ic_fill_data, 0);
    vb = '{32'h0000_3000, 1, 0, 0, 0, -1,
           {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
            64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001},
           32'h0000_3000, 7, 1'b1};
    run_fill(vb, 1'b0, 1'b0, 32'h0);

    // Back-to-back: miss held through ACK, new line right after.
    acks0 = ack_cnt;
    vc = '{32'h0000_0500, 1, 0, 0, 0, -1,
           {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
            64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001},
           32'h0000_0500, 7, 1'b1};
    vd = '{32'h0000_0100, 1, 0, 0, 0, -1,
           {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
            64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001},
           32'h0000_0100, 7, 1'b1};
    run_fill(vc, 1'b0, 1'b1, 32'h0000_0100);
    chk("b2b_idle_req", bus.mem_req, 0);
    run_fill(vd, 1'b1, 1'b0, 32'h0);
    chk("b2b_ack_count", ack_cnt - acks0, 2);

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
